fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end: owns the PC register, drives the instruction-memory request/response interface and writes the IF/ID pipeline register. It consumes the hazard unit's `pc_enable`/`if_id_enable` freeze requests and the EX-stage branch redirect. It buffers a returning instruction while the pipeline is frozen and squashes wrong-path fetches.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013: value held in `if_id_instr` when no valid instruction is present.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_enable`  in  1  hazard unit: 0 = freeze PC.
- `if_id_enable`  in  1  hazard unit: 0 = hold IF/ID.
- `br_taken`  in  1  branch/jump redirect strobe.
- `br_target`  in  XLEN  redirect address; bits [1:0] treated as 0.
- `im_req`  out  1  one-cycle fetch request.
- `im_addr`  out  XLEN  fetch address, valid with `im_req`.
- `im_rvalid`  in  1  response strobe, at least 1 cycle after the request.
- `im_rdata`  in  XLEN  instruction, valid with `im_rvalid`.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  XLEN  PC of IF/ID instruction.
- `if_id_instr`  out  XLEN  IF/ID instruction.

## Operation
- At most one request is outstanding. The memory returns exactly one `im_rvalid` per request, in order.
- `advance` = `pc_enable & if_id_enable`. The block delivers an instruction only when `advance` = 1.
- FSM states:
  - REQ: no request outstanding. `im_req`=1, `im_addr`=`pc_q`, unless `br_taken`. Go to WAIT.
  - WAIT: request outstanding at `pc_q`. On `im_rvalid`:
    - if `advance`, deliver `im_rdata`, set `pc_q`+=4, issue the next request (`im_req`=1, `im_addr`=`pc_q`+4) the same cycle, and stay in WAIT;
    - otherwise capture `im_rdata` in `buf_q` and go to HOLD.
  - HOLD: instruction is in `buf_q`, no request outstanding. On `advance`, deliver `buf_q`, set `pc_q`+=4 and go to REQ.
  - DROP: a wrong-path request is outstanding. On `im_rvalid`, discard the data and go to REQ.
- Deliver = IF/ID <= {1, `pc_q`, instruction}.
- IF/ID update, in priority order:
  1. `br_taken` sets `if_id_valid`<=0 and `if_id_instr`<=NOP_INSTR.
  2. When `if_id_enable`=0, IF/ID holds.
  3. Deliver.
  4. Otherwise `if_id_valid`<=0 and `if_id_instr`<=NOP_INSTR (bubble).
- Redirect (`br_taken`=1) overrides everything and sets `pc_q`<=`br_target`. It is not gated by `pc_enable`. By state:
  - REQ: `im_req` is suppressed this cycle; stay in REQ.
  - WAIT without `im_rvalid`: go to DROP.
  - WAIT with `im_rvalid`: discard the data, no new request; go to REQ.
  - HOLD: discard `buf_q`; go to REQ.
  - DROP without `im_rvalid`: stay in DROP. With `im_rvalid`: go to REQ.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000.
- `if_id_enable`=1 with `pc_enable`=0 gives a bubble in IF/ID while the PC and any pending instruction are preserved.

## Timing
- Reset values: state=REQ, `pc_q`=RESET_PC, `buf_q`=0, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=NOP_INSTR, `im_req`=0 while `rst`=1.
- First `im_req` (`im_addr`=RESET_PC) occurs in the first cycle after `rst` deasserts.
- Zero-wait memory (`im_rvalid` one cycle after `im_req`) with `advance`=1 sustains one instruction per cycle.
- Latency: `im_rvalid` in cycle T gives `if_id_valid`=1 in T+1.
- `br_taken` in cycle T gives `im_req` with `im_addr`=`br_target` in T+1 (from REQ/HOLD), or in the cycle after the dropped response (from WAIT/DROP). Earliest valid target instruction is in IF/ID at T+3.
- `rst` asserted mid-operation: all state returns to reset values immediately. A response still in flight after reset is a memory-side protocol violation and is not handled.
- `im_addr` is valid only while `im_req`=1; its value is otherwise don't-care.

## Test plan
- Reset/stream: release `rst`, zero-wait memory returning addr^0xA5A5_0000 -> IF/ID shows pc 0x0,0x4,0x8,0xC on consecutive cycles with `if_id_valid`=1.
- Freeze: `pc_enable`=`if_id_enable`=0 for 3 cycles while the 0x8 response returns -> IF/ID holds the 0x4 instruction, no `im_req`, HOLD. Release -> 0x8 delivered on the next edge, then request 0xC.
- Split enables: `if_id_enable`=1, `pc_enable`=0 for 2 cycles -> two bubbles (`if_id_valid`=0, instr=0x0000_0013), PC unchanged, no instruction lost.
- Redirect in flight: 3-cycle-latency memory, `br_taken`=1 with target 0x100 one cycle after the 0x10 request -> the 0x10 response is dropped, next `im_addr`=0x100, IF/ID flushed, 0x100 instruction valid next.
- Redirect with frozen pipeline: HOLD plus `br_taken` (target 0x203, `pc_enable`=0) -> `buf_q` discarded, request at 0x200, IF/ID flushed.
- Wrap/reset: redirect to 0xFFFF_FFFC -> next fetch 0x0. Assert `rst` while in WAIT -> outputs at reset values asynchronously, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding instruction-memory
// requests, a one-entry response buffer for frozen pipelines, and the IF/ID register.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_enable,
    input  logic            if_id_enable,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_rvalid,
    input  logic [XLEN-1:0] im_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;

    logic            advance;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] br_target_aligned;
    logic            req_raw;

    assign advance           = pc_enable & if_id_enable;
    assign pc_inc            = pc_q + PcStep;
    assign br_target_aligned = {br_target[XLEN-1:2], 2'b00};

    // Fetch FSM next state, PC and request generation.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        req_raw       = 1'b0;
        im_addr       = pc_q;
        deliver       = 1'b0;
        deliver_instr = im_rdata;

        if (br_taken) begin
            // Redirect wins over freeze; an in-flight request must still be drained.
            pc_d = br_target_aligned;
            unique case (state_q)
                StReq:   state_d = StReq;
                StWait:  state_d = im_rvalid ? StReq : StDrop;
                StHold:  state_d = StReq;
                StDrop:  state_d = im_rvalid ? StReq : StDrop;
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    req_raw = 1'b1;
                    im_addr = pc_q;
                    state_d = StWait;
                end
                StWait: begin
                    if (im_rvalid) begin
                        if (advance) begin
                            deliver       = 1'b1;
                            deliver_instr = im_rdata;
                            pc_d          = pc_inc;
                            req_raw       = 1'b1;
                            im_addr       = pc_inc;
                        end else begin
                            buf_d   = im_rdata;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (advance) begin
                        deliver       = 1'b1;
                        deliver_instr = buf_q;
                        pc_d          = pc_inc;
                        state_d       = StReq;
                    end
                end
                StDrop: begin
                    if (im_rvalid) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    // Reset state is StReq, so the request must be masked while reset is held.
    assign im_req = req_raw & ~rst;

    // IF/ID register next state: flush, hold, deliver, else bubble.
    always_comb begin
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if (br_taken) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (!if_id_enable) begin
            if_id_valid_d = if_id_valid_q;
        end else if (deliver) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = deliver_instr;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            buf_q         <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;

endmodule
